// File: rtl/seq_bin2bcd_pkg.sv
// Shared constants for the iterative double-dabble binary-to-BCD converter:
// FSM state encoding and the per-digit adjust rule.
package seq_bin2bcd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_OFFSET = 4'd3;

    // Valid BCD digits 0..9 map to at most 12, so the add never leaves the nibble.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= ADJ_THRESH) ? (nib + ADJ_OFFSET) : nib;
    endfunction

endpackage

// File: rtl/seq_bin2bcd_digit_adj.sv
// Single-digit double-dabble correction: add 3 when the nibble is 5 or more.
module bcd_digit_adj
    import seq_bin2bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = dabble_adj(nib_i);

endmodule

// File: rtl/seq_bin2bcd.sv
// Iterative binary-to-packed-BCD converter, one bit per clock, held output.
// Optional two's-complement input handling under SEQ_BIN2BCD_SIGNED_EN.
module seq_bin2bcd
    import seq_bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [SW-1:0]    sh_q,    sh_d;
    logic [BW-1:0]    bcd_q,   bcd_d;
    logic             done_q,  done_d;
    logic [BW-1:0]    bcd_adj;
    logic [WIDTH-1:0] mag;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib_i (sh_q[WIDTH + 4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

`ifdef SEQ_BIN2BCD_SIGNED_EN
    logic sgn_q, neg_q;

    assign mag = binary[WIDTH-1] ? (-binary) : binary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) sgn_q <= binary[WIDTH-1];
            if (state_q == ST_DONE)          neg_q <= sgn_q;
        end
    end

    assign neg = neg_q;
`else
    assign mag = binary;
    assign neg = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d    = {{BW{1'b0}}, mag};
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                sh_d  = {bcd_adj, sh_q[WIDTH-1:0]} << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                bcd_d   = sh_q[SW-1:WIDTH];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    // The done cycle still counts as busy so busy spans the whole latency;
    // a new start is already accepted in that cycle since state is IDLE.
    assign busy = (state_q != ST_IDLE) || done_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed-vector bench for seq_bin2bcd (default 16-bit, 5-digit build).
module tb_seq_bin2bcd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] binary;
    logic        busy, done, neg;
    logic [19:0] bcd;

    int n_chk = 0;
    int n_err = 0;
    logic [19:0] last_exp = '0;

    seq_bin2bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .binary (binary),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .neg    (neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input logic [15:0] v);
        int m;
        logic [19:0] r;
`ifdef SEQ_BIN2BCD_SIGNED_EN
        m = v[15] ? (65536 - int'(v)) : int'(v);
`else
        m = int'(v);
`endif
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] vf(input int j);
        return 16'((j * 1237 + 11) & 16'hFFFF);
    endfunction

    task automatic run(input string tag, input logic [15:0] val,
                       input logic [19:0] exp_bcd, input logic exp_neg);
        int lat, bcnt, dcnt;
        logic early;
        logic [19:0] got_bcd;
        logic got_neg;
        lat = -1; bcnt = 0; dcnt = 0; early = 1'b0;
        got_bcd = 'x; got_neg = 1'bx;
        @(negedge clk);
        start = 1'b1; binary = val;
        @(posedge clk); #1;
        start = 1'b0; binary = ~val;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) begin lat = i; got_bcd = bcd; got_neg = neg; end
            end else if (lat < 0 && bcd !== last_exp) begin
                early = 1'b1;
            end
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk({tag, "/latency"}, 32'(lat), 32'd17);
        chk({tag, "/busy_cycles"}, 32'(bcnt), 32'd18);
        chk({tag, "/done_pulses"}, 32'(dcnt), 32'd1);
        chk({tag, "/bcd"}, 32'(got_bcd), 32'(exp_bcd));
        chk({tag, "/neg"}, 32'(got_neg), 32'(exp_neg));
        chk({tag, "/no_early_change"}, 32'(early), 32'd0);
        chk({tag, "/bcd_held"}, 32'(bcd), 32'(exp_bcd));
        last_exp = exp_bcd;
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; binary = '0;
        #1;
        chk("reset/bcd", 32'(bcd), 32'h0);
        chk("reset/busy", 32'(busy), 32'h0);
        chk("reset/done", 32'(done), 32'h0);
        chk("reset/neg", 32'(neg), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("zero", 16'd0, 20'h00000, 1'b0);
        run("one", 16'd1, 20'h00001, 1'b0);
        run("ten_k", 16'd10000, 20'h10000, 1'b0);
        run("9999", 16'd9999, 20'h09999, 1'b0);
`ifdef SEQ_BIN2BCD_SIGNED_EN
        run("neg5", 16'hFFFB, 20'h00005, 1'b1);
        run("min", 16'h8000, 20'h32768, 1'b1);
        run("neg1", 16'hFFFF, 20'h00001, 1'b1);
        run("max_pos", 16'h7FFF, 20'h32767, 1'b0);
`else
        run("max", 16'd65535, 20'h65535, 1'b0);
        run("33107", 16'd33107, 20'h33107, 1'b0);
        run("fffb", 16'hFFFB, 20'h65531, 1'b0);
`endif

        // start held high, binary changing every cycle
        bad = 0;
        @(negedge clk);
        start = 1'b1; binary = vf(0);
        for (int j = 0; j < 54; j++) begin
            @(posedge clk); #1;
            binary = vf(j + 1);
            if (j == 17 || j == 35 || j == 53) begin
                chk($sformatf("stream/done@%0d", j), 32'(done), 32'd1);
                chk($sformatf("stream/bcd@%0d", j), 32'(bcd), 32'(to_bcd(vf(j - 17))));
            end else if (done) begin
                bad++;
            end
        end
        start = 1'b0;
        chk("stream/stray_done", 32'(bad), 32'd0);
        last_exp = to_bcd(vf(36));

        // start during DONE state is ignored
        @(negedge clk);
        start = 1'b1; binary = 16'd2024;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin @(posedge clk); #1; end
        start = 1'b1; binary = 16'd7777;
        @(posedge clk); #1;
        start = 1'b0;
        chk("dstart/done", 32'(done), 32'd1);
        chk("dstart/bcd", 32'(bcd), 32'h02024);
        @(posedge clk); #1;
        chk("dstart/busy_low", 32'(busy), 32'd0);
        chk("dstart/done_low", 32'(done), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("dstart/bcd_kept", 32'(bcd), 32'h02024);
        chk("dstart/still_idle", 32'(busy), 32'd0);

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        start = 1'b1; binary = 16'd12345;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("rst/bcd", 32'(bcd), 32'h0);
        chk("rst/busy", 32'(busy), 32'h0);
        chk("rst/done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        chk("rst/no_resume", 32'(bad), 32'd0);
        last_exp = '0;
        run("after_rst", 16'd999, 20'h00999, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
